inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 115 +++++++++++
 tb/tb_inst_fetch.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - byte-serial instruction fetch with one-word output slot and a second held word
// Four byte reads are assembled little-endian into a 32-bit instruction per fetch_pc.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
);

  typedef enum logic {
    FETCH = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h0000_0003;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_reg;
  logic [31:0] asm_pc;

  logic        xfer;
  logic        slot_free;
  logic        fetch_ack;
  logic        word_done;
  logic        load_fetch;
  logic        load_held;
  logic [31:0] asm_word;

  // The request is gated by rst_n so it is low throughout reset yet
  // appears in the very first cycle after release.
  assign imem_req  = rst_n && (state == FETCH);
  assign imem_addr = fetch_pc + {30'b0, byte_cnt};

  assign xfer       = inst_valid && !stall;
  assign slot_free  = !inst_valid || xfer;
  assign fetch_ack  = (state == FETCH) && imem_ack;
  assign word_done  = fetch_ack && (byte_cnt == 2'd3);
  assign load_fetch = word_done && slot_free;
  assign load_held  = (state == FULL) && slot_free;
  assign asm_word   = {imem_rdata, asm_reg[23:0]};

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = FETCH;
    end else begin
      case (state)
        FETCH:   if (word_done && !slot_free) state_nxt = FULL;
        FULL:    if (slot_free)               state_nxt = FETCH;
        default: state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC_ALIGNED;
      byte_cnt   <= 2'd0;
      asm_reg    <= 32'h0;
      asm_pc     <= 32'h0;
      inst_valid <= 1'b0;
      inst_out   <= 32'h0;
      pc_out     <= 32'h0;
    end else if (redirect_valid) begin
      fetch_pc   <= redirect_pc & ~32'h0000_0003;
      byte_cnt   <= 2'd0;
      asm_reg    <= 32'h0;
      inst_valid <= 1'b0;
    end else begin
      if (fetch_ack) begin
        // Lane 3 is written too, so a word that cannot leave yet is already whole in asm_reg.
        asm_reg[{byte_cnt, 3'b000} +: 8] <= imem_rdata;
        byte_cnt <= byte_cnt + 2'd1;
        if (word_done) begin
          asm_pc <= fetch_pc;
        end
      end

      if (load_fetch) begin
        inst_valid <= 1'b1;
        inst_out   <= asm_word;
        pc_out     <= fetch_pc;
        fetch_pc   <= fetch_pc + 32'd4;
      end else if (load_held) begin
        inst_valid <= 1'b1;
        inst_out   <= asm_reg;
        pc_out     <= asm_pc;
        fetch_pc   <= fetch_pc + 32'd4;
      end else if (xfer) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed checks of inst_fetch against hand-computed words
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_ack;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;

  logic        imem_req,   imem_req_w;
  logic [31:0] imem_addr,  imem_addr_w;
  logic [7:0]  imem_rdata, imem_rdata_w;
  logic        inst_valid, inst_valid_w;
  logic [31:0] inst_out,   inst_out_w;
  logic [31:0] pc_out,     pc_out_w;

  int total = 0;
  int bad   = 0;

  // Memory image: a fixed instruction at 0..3, address ^ 8'hA5 elsewhere.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0:   mem_byte = 8'h20;
      32'h1:   mem_byte = 8'h20;
      32'h2:   mem_byte = 8'h43;
      32'h3:   mem_byte = 8'h00;
      default: mem_byte = a[7:0] ^ 8'hA5;
    endcase
  endfunction

  assign imem_rdata   = mem_byte(imem_addr);
  assign imem_rdata_w = mem_byte(imem_addr_w);

  inst_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .inst_valid(inst_valid), .inst_out(inst_out), .pc_out(pc_out)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata_w),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .inst_valid(inst_valid_w), .inst_out(inst_out_w), .pc_out(pc_out_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] prev_addr;
  logic        prev_ack;

  initial begin
    rst_n          = 1'b0;
    imem_ack       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;
    repeat (3) tick();

    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst",  inst_out, 32'h0);
    chk("rst_pc",    pc_out, 32'h0);
    chk("rst_req",   {31'b0, imem_req}, 32'h0);

    // Basic fetch
    rst_n = 1'b1;
    #1;
    chk("first_req",  {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_addr_w", imem_addr_w, 32'hFFFF_FFFC);
    tick(); chk("addr1", imem_addr, 32'h1);
    tick(); chk("addr2", imem_addr, 32'h2);
    tick(); chk("addr3", imem_addr, 32'h3);
    chk("not_yet_valid", {31'b0, inst_valid}, 32'h0);
    tick();
    chk("w0_valid", {31'b0, inst_valid}, 32'h1);
    chk("w0_inst",  inst_out, 32'h0043_2020);
    chk("w0_pc",    pc_out, 32'h0);
    chk("wrap_valid", {31'b0, inst_valid_w}, 32'h1);
    chk("wrap_inst",  inst_out_w, 32'h5A5B_5859);
    chk("wrap_pc",    pc_out_w, 32'hFFFF_FFFC);

    // Backpressure: second word is held, then request drops
    stall = 1'b1;
    repeat (3) tick();
    chk("stall_req_before_full", {31'b0, imem_req}, 32'h1);
    tick();
    chk("full_req", {31'b0, imem_req}, 32'h0);
    repeat (6) tick();
    chk("stall_valid", {31'b0, inst_valid}, 32'h1);
    chk("stall_inst",  inst_out, 32'h0043_2020);
    chk("stall_pc",    pc_out, 32'h0);
    chk("stall_req",   {31'b0, imem_req}, 32'h0);
    stall = 1'b0;
    tick();
    chk("w1_valid", {31'b0, inst_valid}, 32'h1);
    chk("w1_inst",  inst_out, 32'hA2A3_A0A1);
    chk("w1_pc",    pc_out, 32'h4);
    chk("resume_req",  {31'b0, imem_req}, 32'h1);
    chk("resume_addr", imem_addr, 32'h8);
    chk("wrap2_inst", inst_out_w, 32'h0043_2020);
    chk("wrap2_pc",   pc_out_w, 32'h0);
    tick();
    chk("drain_valid", {31'b0, inst_valid}, 32'h0);
    repeat (3) tick();
    chk("w2_valid", {31'b0, inst_valid}, 32'h1);
    chk("w2_inst",  inst_out, 32'hAEAF_ACAD);
    chk("w2_pc",    pc_out, 32'h8);

    // Slow memory: ack every third cycle
    for (int i = 0; i < 12; i++) begin
      prev_addr = imem_addr;
      prev_ack  = (i % 3 == 2);
      imem_ack  = prev_ack;
      tick();
      if (!prev_ack) chk("slow_addr_hold", imem_addr, prev_addr);
    end
    chk("w3_valid", {31'b0, inst_valid}, 32'h1);
    chk("w3_inst",  inst_out, 32'hAAAB_A8A9);
    chk("w3_pc",    pc_out, 32'hC);

    // Redirect while byte 2 of the word at 0x10 is being requested
    imem_ack = 1'b1;
    tick(); tick();
    chk("pre_redir_addr", imem_addr, 32'h12);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2B;
    tick();
    redirect_valid = 1'b0;
    chk("redir_addr",  imem_addr, 32'h28);
    chk("redir_valid", {31'b0, inst_valid}, 32'h0);
    chk("redir_req",   {31'b0, imem_req}, 32'h1);
    repeat (3) tick();
    chk("redir_no_partial", {31'b0, inst_valid}, 32'h0);
    tick();
    chk("w4_valid", {31'b0, inst_valid}, 32'h1);
    chk("w4_inst",  inst_out, 32'h8E8F_8C8D);
    chk("w4_pc",    pc_out, 32'h28);

    // Asynchronous reset mid-word
    stall = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", {31'b0, inst_valid}, 32'h0);
    chk("async_inst",  inst_out, 32'h0);
    chk("async_pc",    pc_out, 32'h0);
    chk("async_req",   {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    stall = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_req_w", {31'b0, imem_req_w}, 32'h1);
    repeat (4) tick();
    chk("restart_valid", {31'b0, inst_valid}, 32'h1);
    chk("restart_inst",  inst_out, 32'h0043_2020);
    chk("restart_pc",    pc_out, 32'h0);
    chk("restart_pc_w",  pc_out_w, 32'hFFFF_FFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
